// File: rtl/adder_pkg.sv
// Shared definitions for the adder board: sequencer state encoding and default datapath width.
package adder_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_mul_sequencer_if.sv
// Request/product handshake plus the time-shared Adder32 connection of the multiplier sequencer.
interface adder_mul_sequencer_if #(
   parameter int WIDTH = adder_pkg::DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] add_operand1;
   logic [WIDTH-1:0] add_operand2;
   logic             add_carry_in;
   logic [WIDTH-1:0] add_result;
   logic             add_carry_out;

   // master = the board top side (LCD logic plus the Adder32 instance)
   modport master (
      output start, multiplicand, multiplier, add_result, add_carry_out,
      input  busy, done, product_hi, product_lo, add_operand1, add_operand2, add_carry_in
   );

   modport slave (
      input  start, multiplicand, multiplier, add_result, add_carry_out,
      output busy, done, product_hi, product_lo, add_operand1, add_operand2, add_carry_in
   );
endinterface

// File: rtl/adder_mul_sequencer.sv
// Shift-and-add 2*WIDTH-bit unsigned multiplier that borrows one external WIDTH-bit adder per iteration.
module adder_mul_sequencer
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic                  clk,
   input  logic                  resetn,
   adder_mul_sequencer_if.slave  bus
);

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_p_hi;
   logic [WIDTH-1:0] r_p_lo;
   logic [CNT_W-1:0] r_cnt;

   // Adder is fed from registers in every state; its result is only consumed in RUN.
   assign bus.add_operand1 = r_p_hi;
   assign bus.add_operand2 = r_p_lo[0] ? r_m : '0;
   assign bus.add_carry_in = 1'b0;

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.product_hi = r_p_hi;
   assign bus.product_lo = r_p_lo;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_m     <= '0;
         r_p_hi  <= '0;
         r_p_lo  <= '0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_m     <= bus.multiplicand;
                  r_p_hi  <= '0;
                  r_p_lo  <= bus.multiplier;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // Carry-out lands in P_hi[MSB], so the WIDTH+1-bit partial sum is never truncated.
               {r_p_hi, r_p_lo} <= {bus.add_carry_out, bus.add_result, r_p_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_mul_sequencer.sv
// Self-checking bench: directed corner cases plus random operands against a plain 64-bit multiply.
module tb_adder_mul_sequencer;

   logic clk;
   logic resetn;
   int   n_chk;
   int   n_err;
   int   n_done;
   logic [31:0] m_ref;

   adder_mul_sequencer_if #(.WIDTH(32)) bus ();

   adder_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // behavioural Adder32
   assign {bus.add_carry_out, bus.add_result} =
      {1'b0, bus.add_operand1} + {1'b0, bus.add_operand2} + {32'd0, bus.add_carry_in};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // adder drive must hold whenever the sequencer is working
   always @(negedge clk) begin
      if (bus.done) n_done++;
      if (resetn && bus.busy) begin
         chk("carry_in", {63'd0, bus.add_carry_in}, 64'd0);
         chk("operand2", {32'd0, bus.add_operand2}, bus.product_lo[0] ? {32'd0, m_ref} : 64'd0);
      end
   end

   // Called #1 after a posedge in an IDLE cycle; returns #1 after the posedge of the done cycle.
   task automatic do_op(input logic [31:0] m, input logic [31:0] q, input bit hold,
                        input int poke, input int abort, output int lat);
      int d0;
      d0 = n_done;
      start_op(m, q);
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 100 && lat != abort) begin
         if (lat == poke) begin
            bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd7;
         end else if (!hold) bus.start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (lat == abort) return;
      chk("latency", 64'(lat), 64'd33);
      chk("product", {bus.product_hi, bus.product_lo}, {32'd0, m} * {32'd0, q});
      if (!hold) begin
         @(posedge clk); #1;
         chk("busy_after", {63'd0, bus.busy}, 64'd0);
         chk("done_count", 64'(n_done - d0), 64'd1);
      end
   endtask

   task automatic start_op(input logic [31:0] m, input logic [31:0] q);
      bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q; m_ref = m;
   endtask

   initial begin
      int lat, k, d0;
      logic [31:0] rm, rq;
      n_chk = 0; n_err = 0; n_done = 0; m_ref = '0;
      resetn = 1'b0; bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
      #12;
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_hi",   {32'd0, bus.product_hi}, 64'd0);
      chk("rst_lo",   {32'd0, bus.product_lo}, 64'd0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      do_op(32'd3, 32'd5, 1'b0, -1, -1, lat);
      chk("p3x5_lo", {32'd0, bus.product_lo}, 64'h0F);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1, lat);
      chk("ones_hi", {32'd0, bus.product_hi}, 64'hFFFF_FFFE);
      chk("ones_lo", {32'd0, bus.product_lo}, 64'h0000_0001);
      do_op(32'h1234_5678, 32'd0, 1'b0, 10, -1, lat);
      chk("zero_prod", {bus.product_hi, bus.product_lo}, 64'd0);

      // asynchronous abort mid-run
      d0 = n_done;
      do_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, -1, 15, lat);
      chk("abort_busy_pre", {63'd0, bus.busy}, 64'd1);
      #3 resetn = 1'b0;
      #1;
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      chk("abort_done", {63'd0, bus.done}, 64'd0);
      chk("abort_prod", {bus.product_hi, bus.product_lo}, 64'd0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      chk("abort_no_done", 64'(n_done - d0), 64'd0);
      do_op(32'h1_0000, 32'h1_0000, 1'b0, -1, -1, lat);
      chk("p16_hi", {32'd0, bus.product_hi}, 64'd1);
      chk("p16_lo", {32'd0, bus.product_lo}, 64'd0);

      // start held high re-triggers in the first IDLE cycle
      do_op(32'd2, 32'h8000_0000, 1'b1, -1, -1, lat);
      k = 0;
      do begin
         @(posedge clk); #1; k++;
      end while (!bus.done && k < 100);
      bus.start = 1'b0;
      chk("spacing", 64'(k), 64'd34);
      chk("hold_prod", {bus.product_hi, bus.product_lo}, 64'h1_0000_0000);
      @(posedge clk); #1;
      chk("hold_busy_after", {63'd0, bus.busy}, 64'd0);

      for (int i = 0; i < 200; i++) begin
         rm = $urandom; rq = $urandom;
         if (i % 50 == 0) rq = 32'hFFFF_FFFF;
         do_op(rm, rq, 1'b0, -1, -1, lat);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
